// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the multi-phase signal sequencer.
// Pure declarations: no state, no latency.
// Not applicable to backpressure: lamps are decoded every cycle.
package phase_seq_pkg;

    // Controller states; exactly one phase may be non-red and only in GREEN/YELLOW
    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_e;

    // Width of a phase index; a two-phase controller still needs one bit
    function automatic int pw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lamp triple {red, yellow, green} for one phase given controller state and selection
    function automatic logic [2:0] lamp_code(input state_e st, input logic sel);
        if (sel && (st == ST_GREEN)) begin
            return 3'b001;
        end else if (sel && (st == ST_YELLOW)) begin
            return 3'b010;
        end
        return 3'b100;
    endfunction

endpackage

// File: rtl/phase_seq_ctrl_rr_pick.sv
// Round-robin picker: first pending phase after last_idx, wrapping, last_idx itself last.
// Latency: purely combinational.
// No backpressure: grant is advisory, the caller decides whether to take it.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  pending_i,
    input  logic [PW-1:0] last_idx_i,
    output logic [N-1:0]  grant_onehot_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          any_o
);

    logic found;
    int   cand;

    // Walk the ring starting one past the last served phase; first hit wins
    always_comb begin
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        found          = 1'b0;
        cand           = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_idx_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && pending_i[cand[PW-1:0]]) begin
                found                          = 1'b1;
                grant_idx_o                    = cand[PW-1:0];
                grant_onehot_o[cand[PW-1:0]]   = 1'b1;
            end
        end
    end

    assign any_o = |pending_i;

endmodule

// File: rtl/phase_seq_ctrl.sv
// Demand-driven multi-phase sequencer with min/max green, yellow and all-red clearance.
// Latency: all outputs registered; a decision taken in cycle n is visible in cycle n+1.
// No backpressure: en=0 freezes timing, force_red overrides everything but reset.
module phase_seq_ctrl
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 32,
    parameter int YELLOW_T   = 4,
    parameter int ALLRED_T   = 2,
    localparam int PW        = pw_f(NUM_PHASES)
) (
    input  logic                  blif_clk_net,
    input  logic                  blif_reset_net,
    input  logic                  en,
    input  logic [NUM_PHASES-1:0] req,
    input  logic                  force_red,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] green,
    output logic [PW-1:0]         phase_idx,
    output logic                  phase_start,
    output logic [CNT_W-1:0]      tcnt
);

    // Thresholds expressed as "last tick of the interval" since tcnt starts at 0 on entry
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [NUM_PHASES-1:0] ONE    = {{(NUM_PHASES-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        tcnt_q, tcnt_d;
    logic [NUM_PHASES-1:0]   pending_q, pending_d;
    logic [PW-1:0]           phase_idx_q, phase_idx_d;
    logic                    phase_start_q, phase_start_d;
    logic [NUM_PHASES-1:0]   red_q, red_d;
    logic [NUM_PHASES-1:0]   yellow_q, yellow_d;
    logic [NUM_PHASES-1:0]   green_q, green_d;

    logic [NUM_PHASES-1:0]   cur_oh;
    logic [NUM_PHASES-1:0]   green_mask;
    logic [NUM_PHASES-1:0]   pick_oh;
    logic [PW-1:0]           pick_idx;
    logic                    pick_any;
    logic                    grant_take;
    logic                    other;
    logic                    gap_out;
    logic                    max_out;

    rr_pick #(
        .N  (NUM_PHASES),
        .PW (PW)
    ) u_pick (
        .pending_i      (pending_q),
        .last_idx_i     (phase_idx_q),
        .grant_onehot_o (pick_oh),
        .grant_idx_o    (pick_idx),
        .any_o          (pick_any)
    );

    assign cur_oh     = ONE << phase_idx_q;
    assign green_mask = (state_q == ST_GREEN) ? cur_oh : '0;
    assign other      = |(pending_q & ~cur_oh);
    assign gap_out    = (tcnt_q >= GMIN_LAST) && !(|(req & cur_oh));
    assign max_out    = (tcnt_q >= GMAX_LAST);

    // Next-state, demand latch and lamp decode of the upcoming state
    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        phase_idx_d   = phase_idx_q;
        phase_start_d = 1'b0;
        grant_take    = 1'b0;
        red_d         = '1;
        yellow_d      = '0;
        green_d       = '0;

        if (en && (tcnt_q != '1)) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (force_red) begin
            state_d = ST_ALL_RED;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                ST_ALL_RED: begin
                    if (en && (tcnt_q >= ALLRED_LAST) && pick_any) begin
                        state_d       = ST_GREEN;
                        tcnt_d        = '0;
                        phase_idx_d   = pick_idx;
                        phase_start_d = 1'b1;
                        grant_take    = 1'b1;
                    end
                end
                ST_GREEN: begin
                    if (en && other && (gap_out || max_out)) begin
                        state_d = ST_YELLOW;
                        tcnt_d  = '0;
                    end
                end
                ST_YELLOW: begin
                    if (en && (tcnt_q == YEL_LAST)) begin
                        state_d = ST_ALL_RED;
                        tcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_ALL_RED;
                    tcnt_d  = '0;
                end
            endcase
        end

        // The served phase's own demand is not latched while it is green
        pending_d = (pending_q | (req & ~green_mask)) & ~(grant_take ? pick_oh : '0);

        for (int i = 0; i < NUM_PHASES; i++) begin
            {red_d[i], yellow_d[i], green_d[i]} = lamp_code(state_d, phase_idx_d == PW'(i));
        end
    end

    // Controller registers; reset dominates every input
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state_q       <= ST_ALL_RED;
            tcnt_q        <= '0;
            pending_q     <= '0;
            phase_idx_q   <= PW'(NUM_PHASES - 1);
            phase_start_q <= 1'b0;
            red_q         <= '1;
            yellow_q      <= '0;
            green_q       <= '0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            pending_q     <= pending_d;
            phase_idx_q   <= phase_idx_d;
            phase_start_q <= phase_start_d;
            red_q         <= red_d;
            yellow_q      <= yellow_d;
            green_q       <= green_d;
        end
    end

    assign red         = red_q;
    assign yellow      = yellow_q;
    assign green       = green_q;
    assign phase_idx   = phase_idx_q;
    assign phase_start = phase_start_q;
    assign tcnt        = tcnt_q;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Scoreboarded bench: directed scenarios followed by random traffic against a reference model.
module tb_phase_seq_ctrl;

    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int GMIN = 8;
    localparam int GMAX = 32;
    localparam int YT   = 4;
    localparam int AT   = 2;
    localparam int TMAX = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         frc = 1'b0;
    logic [N-1:0] req = '0;

    logic [N-1:0]  red, yellow, green;
    logic [1:0]    phase_idx;
    logic          phase_start;
    logic [CW-1:0] tcnt;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] y;
        logic [3:0] g;
        logic [1:0] idx;
        logic       st;
        logic [7:0] t;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: mode 0=all red, 1=green, 2=yellow; pend is a bitmask
    int m_mode = 0;
    int m_idx  = N - 1;
    int m_el   = 0;
    int m_pend = 0;

    phase_seq_ctrl #(
        .NUM_PHASES (N),
        .CNT_W      (CW),
        .GREEN_MIN  (GMIN),
        .GREEN_MAX  (GMAX),
        .YELLOW_T   (YT),
        .ALLRED_T   (AT)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .en             (en),
        .req            (req),
        .force_red      (frc),
        .red            (red),
        .yellow         (yellow),
        .green          (green),
        .phase_idx      (phase_idx),
        .phase_start    (phase_start),
        .tcnt           (tcnt)
    );

    always #5 clk = ~clk;

    function automatic int bump(input int v);
        return (v < TMAX) ? v + 1 : v;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit f, input int rq, output obs_t o);
        int  nxt_pend;
        int  others;
        int  pick;
        int  c;
        bit  st;
        logic [3:0] gv, yv;
        st = 1'b0;
        if (r) begin
            m_mode = 0; m_el = 0; m_pend = 0; m_idx = N - 1;
        end else begin
            nxt_pend = m_pend | (rq & ~((m_mode == 1) ? (1 << m_idx) : 0));
            if (f) begin
                m_mode = 0; m_el = 0;
            end else if (m_mode == 0) begin
                if (e && m_el >= AT - 1 && m_pend != 0) begin
                    pick = -1;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_idx + k) % N;
                        if (pick < 0 && ((m_pend >> c) & 1) != 0) pick = c;
                    end
                    m_idx = pick; m_mode = 1; m_el = 0; st = 1'b1;
                    nxt_pend = nxt_pend & ~(1 << pick);
                end else if (e) begin
                    m_el = bump(m_el);
                end
            end else if (m_mode == 1) begin
                others = m_pend & ~(1 << m_idx);
                if (e && others != 0 &&
                    ((m_el >= GMIN - 1 && ((rq >> m_idx) & 1) == 0) || m_el >= GMAX - 1)) begin
                    m_mode = 2; m_el = 0;
                end else if (e) begin
                    m_el = bump(m_el);
                end
            end else begin
                if (e && m_el == YT - 1) begin
                    m_mode = 0; m_el = 0;
                end else if (e) begin
                    m_el = bump(m_el);
                end
            end
            m_pend = nxt_pend;
        end
        gv = (m_mode == 1) ? 4'(1 << m_idx) : 4'h0;
        yv = (m_mode == 2) ? 4'(1 << m_idx) : 4'h0;
        o.g   = gv;
        o.y   = yv;
        o.r   = ~(gv | yv);
        o.idx = 2'(m_idx);
        o.st  = st;
        o.t   = 8'(m_el);
    endtask

    // Apply one cycle of inputs and queue what the DUT must show after the next edge
    task automatic drive(input bit r, input bit e, input bit f, input logic [3:0] rq);
        obs_t o;
        @(negedge clk);
        rst = r; en = e; frc = f; req = rq;
        model_step(r, e, f, int'(rq), o);
        exp_q.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 4'h0);
    endtask

    // Monitor: compare every presented output cycle against the queued expectation
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.r = red; a.y = yellow; a.g = green;
                a.idx = phase_idx; a.st = phase_start; a.t = tcnt;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL lamps_state @%0t got r=%h y=%h g=%h idx=%0d start=%b tcnt=%0d want r=%h y=%h g=%h idx=%0d start=%b tcnt=%0d",
                             $time, a.r, a.y, a.g, a.idx, a.st, a.t, e.r, e.y, e.g, e.idx, e.st, e.t);
                end
            end
        end
    end

    initial begin
        // Reset, then idle with no demand
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 4'h0);
        idle(100);
        // Single demand pulse on phase 2, then rest in green
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        idle(200);
        // Competing pulse on phase 0: gap-out of phase 2
        drive(1'b0, 1'b1, 1'b0, 4'b0001);
        idle(40);
        // Phase 2 held high with phase 0 demand: max-out
        for (int i = 0; i < 80; i++)
            drive(1'b0, 1'b1, 1'b0, (i == 30) ? 4'b0101 : 4'b0100);
        idle(30);
        // Serve phase 3, then wrap to 1 and 2
        drive(1'b0, 1'b1, 1'b0, 4'b1000);
        idle(25);
        drive(1'b0, 1'b1, 1'b0, 4'b0110);
        idle(80);
        // Tick enable dropped for 10 cycles inside green
        drive(1'b0, 1'b1, 1'b0, 4'b0001);
        idle(4);
        drive(1'b0, 1'b1, 1'b0, 4'b1000);
        idle(2);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 4'h0);
        idle(40);
        // Emergency override mid-cycle, then reset mid-green
        drive(1'b0, 1'b1, 1'b0, 4'b0010);
        idle(12);
        drive(1'b0, 1'b1, 1'b1, 4'h0);
        idle(20);
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        idle(6);
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        idle(20);
        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            bit         r, e, f;
            logic [3:0] rq;
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 9) != 0);
            f  = ($urandom_range(0, 59) == 0);
            rq = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            drive(r, e, f, rq);
        end
        idle(3);
        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
